// File: rtl/conv_tap_scheduler.sv
// conv_tap_scheduler
//   Walks a KxK convolution kernel over an FxF feature map with zero padding P
//   and stride S. Issues one tap per non-stalled cycle: outputs in raster order
//   on the outside, kernel taps in raster order on the inside. Padded taps are
//   still issued so the DSP cascade sees a fixed K*K tap count per window. The
//   output write is produced PIPE_LAT cycles after each window's last tap.
//
// Ports
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_go        : start pulse, sampled only when idle
//   i_stall     : back-pressure, holds tap issue while running
//   o_fm_addr   : feature-map read address (row*F + col)
//   o_fm_rd     : feature-map read strobe (in-range taps only)
//   o_pad_zero  : tap lies in the padding border, DSP input forced to zero
//   o_w_addr    : weight address (kr*K + kc)
//   o_tap_valid : a tap is issued this cycle
//   o_acc_clr   : first tap of a window
//   o_acc_last  : last tap of a window
//   o_out_we    : output write enable
//   o_out_addr  : output address (orow*OUT + ocol)
//   o_busy      : scheduler is not idle
//   o_done      : one-cycle completion pulse
module conv_tap_scheduler #(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 8,
    parameter int PADDING     = 1,
    parameter int STRIDE      = 1,
    parameter int PIPE_LAT    = 3,
    localparam int OUT_SIZE   = ((FM_SIZE - KERNEL_SIZE + 2*PADDING) / STRIDE) + 1,
    localparam int FA_W = ($clog2(FM_SIZE*FM_SIZE) > 0) ? $clog2(FM_SIZE*FM_SIZE) : 1,
    localparam int WA_W = ($clog2(KERNEL_SIZE*KERNEL_SIZE) > 0) ? $clog2(KERNEL_SIZE*KERNEL_SIZE) : 1,
    localparam int OA_W = ($clog2(OUT_SIZE*OUT_SIZE) > 0) ? $clog2(OUT_SIZE*OUT_SIZE) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_go,
    input  logic            i_stall,
    output logic [FA_W-1:0] o_fm_addr,
    output logic            o_fm_rd,
    output logic            o_pad_zero,
    output logic [WA_W-1:0] o_w_addr,
    output logic            o_tap_valid,
    output logic            o_acc_clr,
    output logic            o_acc_last,
    output logic            o_out_we,
    output logic [OA_W-1:0] o_out_addr,
    output logic            o_busy,
    output logic            o_done
);

    localparam int KC_W = ($clog2(KERNEL_SIZE) > 0) ? $clog2(KERNEL_SIZE) : 1;
    localparam int OC_W = ($clog2(OUT_SIZE) > 0) ? $clog2(OUT_SIZE) : 1;
    // Signed coordinate width with headroom for the negative padding offset
    // and the largest row*S + kr intermediate.
    localparam int CW   = $clog2(FM_SIZE + 2*PADDING + KERNEL_SIZE + 1) + 2;

    localparam logic signed [CW-1:0] F_S      = CW'(FM_SIZE);
    localparam logic [KC_W-1:0]      K_LAST   = KC_W'(KERNEL_SIZE - 1);
    localparam logic [OC_W-1:0]      O_LAST   = OC_W'(OUT_SIZE - 1);
    localparam logic [OA_W-1:0]      WIN_LAST = OA_W'(OUT_SIZE*OUT_SIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [OC_W-1:0]  orow, ocol;
    logic [KC_W-1:0]  kr, kc;

    // Tracks {window-last flag, window index} toward the output write.
    logic             pipe_last [PIPE_LAT];
    logic [OA_W-1:0]  pipe_idx  [PIPE_LAT];

    logic signed [CW-1:0] ir_c, ic_c;
    logic                 tap_pad, tap_first, tap_last, last_win, issue;
    logic [FA_W-1:0]      tap_fm_addr;
    logic [WA_W-1:0]      tap_w_addr;
    logic [OA_W-1:0]      win_idx;

    // Decode of the tap currently pointed at by the counters. The counters
    // always hold the next tap to issue, which lets the very first tap go out
    // on the same edge that samples i_go.
    always_comb begin
        ir_c        = CW'(orow) * CW'(STRIDE) + CW'(kr) - CW'(PADDING);
        ic_c        = CW'(ocol) * CW'(STRIDE) + CW'(kc) - CW'(PADDING);
        tap_pad     = ir_c[CW-1] | ic_c[CW-1] | !(ir_c < F_S) | !(ic_c < F_S);
        tap_fm_addr = FA_W'($unsigned(ir_c)) * FA_W'(FM_SIZE) + FA_W'($unsigned(ic_c));
        tap_w_addr  = WA_W'(kr) * WA_W'(KERNEL_SIZE) + WA_W'(kc);
        win_idx     = OA_W'(orow) * OA_W'(OUT_SIZE) + OA_W'(ocol);
        tap_first   = (kr == '0) && (kc == '0);
        tap_last    = (kr == K_LAST) && (kc == K_LAST);
        last_win    = (orow == O_LAST) && (ocol == O_LAST);
        issue       = ((state == IDLE) && i_go) || ((state == RUN) && !i_stall);
    end

    // Control FSM, counters, latency pipe and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            orow        <= '0;
            ocol        <= '0;
            kr          <= '0;
            kc          <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_last[i] <= 1'b0;
                pipe_idx[i]  <= '0;
            end
            o_fm_addr   <= '0;
            o_fm_rd     <= 1'b0;
            o_pad_zero  <= 1'b0;
            o_w_addr    <= '0;
            o_tap_valid <= 1'b0;
            o_acc_clr   <= 1'b0;
            o_acc_last  <= 1'b0;
            o_out_we    <= 1'b0;
            o_out_addr  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            // Tap outputs are zero whenever nothing is issued (idle or stalled).
            o_tap_valid <= issue;
            o_fm_rd     <= issue && !tap_pad;
            o_pad_zero  <= issue && tap_pad;
            o_fm_addr   <= (issue && !tap_pad) ? tap_fm_addr : '0;
            o_w_addr    <= issue ? tap_w_addr : '0;
            o_acc_clr   <= issue && tap_first;
            o_acc_last  <= issue && tap_last;

            // Stage 0 mirrors o_acc_last, so the last stage turns into the
            // write exactly PIPE_LAT cycles later. Never frozen by the stall.
            pipe_last[0] <= issue && tap_last;
            pipe_idx[0]  <= win_idx;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_last[i] <= pipe_last[i-1];
                pipe_idx[i]  <= pipe_idx[i-1];
            end
            o_out_we   <= pipe_last[PIPE_LAT-1];
            o_out_addr <= pipe_last[PIPE_LAT-1] ? pipe_idx[PIPE_LAT-1] : '0;
            o_done     <= 1'b0;

            // Raster advance: kc fastest, then kr, then ocol, then orow.
            if (issue) begin
                if (kc == K_LAST) begin
                    kc <= '0;
                    if (kr == K_LAST) begin
                        kr <= '0;
                        if (ocol == O_LAST) begin
                            ocol <= '0;
                            orow <= (orow == O_LAST) ? '0 : orow + 1'b1;
                        end else begin
                            ocol <= ocol + 1'b1;
                        end
                    end else begin
                        kr <= kr + 1'b1;
                    end
                end else begin
                    kc <= kc + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_go) begin
                        // A 1x1 job finishes issuing on the starting edge.
                        state  <= (tap_last && last_win) ? DRAIN : RUN;
                        o_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && tap_last && last_win)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pipe_last[PIPE_LAT-1] && (pipe_idx[PIPE_LAT-1] == WIN_LAST))
                        state <= DONE;
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_tap_scheduler.md
CONV_TAP_SCHEDULER -- requirements
Module: conv_tap_scheduler

Interface
REQ-001 KERNEL_SIZE, default 3: square kernel side K.
REQ-002 FM_SIZE, default 8: square input feature-map side F.
REQ-003 PADDING, default 1: zero border P on every side.
REQ-004 STRIDE, default 1: window step S.
REQ-005 PIPE_LAT, default 3: cycles from the last-tap issue to the DSP cascade result being valid; legal range 1..8.
REQ-006 OUT_SIZE, localparam: ((F-K+2P)/S)+1.
REQ-007 i_clk  input  1: the single clock; all logic is on the rising edge.
REQ-008 i_rst  input  1: reset, synchronous and active-high.
REQ-009 i_go  input  1: start pulse; sampled only in IDLE.
REQ-010 i_stall  input  1: back-pressure; freezes tap issue.
REQ-011 o_fm_addr  output  $clog2(F*F): feature-map read address, row*F+col.
REQ-012 o_fm_rd  output  1: feature-map read strobe.
REQ-013 o_pad_zero  output  1: the tap lies in padding; the DSP input is forced to zero.
REQ-014 o_w_addr  output  $clog2(K*K): weight address, kr*K+kc.
REQ-015 o_tap_valid  output  1: a tap is issued this cycle.
REQ-016 o_acc_clr  output  1: first tap of a window; the accumulator restarts.
REQ-017 o_acc_last  output  1: last tap of a window.
REQ-018 o_out_we  output  1: output write enable.
REQ-019 o_out_addr  output  $clog2(OUT_SIZE*OUT_SIZE): output address, orow*OUT_SIZE+ocol.
REQ-020 o_busy  output  1: state is not IDLE.
REQ-021 o_done  output  1: one-cycle completion pulse.

Function
REQ-022 FSM states and transitions:
- IDLE -> RUN on i_go.
- RUN -> DRAIN after the last tap of the last window is issued.
- DRAIN -> DONE once the final o_out_we has been asserted.
- DONE -> IDLE after one cycle.
REQ-023 Iteration order, in raster order, is outputs (orow, ocol) as the outer loop and taps (kr, kc) as the inner loop, at one tap per non-stalled RUN cycle.
REQ-024 The first tap is issued in the cycle after i_go is sampled in IDLE.
REQ-025 Tap coordinates are ir = orow*S + kr - P and ic = ocol*S + kc - P, computed signed with at least 1 bit of headroom.
REQ-026 If ir or ic is outside 0..F-1, then o_pad_zero=1, o_fm_rd=0 and o_fm_addr=0.
REQ-027 If ir and ic are in range, then o_fm_rd=1, o_pad_zero=0 and o_fm_addr=ir*F+ic.
REQ-028 o_tap_valid=1 on every issued tap, padded or not; o_w_addr is valid on every issued tap.
REQ-029 o_acc_clr=1 on tap (0,0) and o_acc_last=1 on tap (K-1,K-1); when K=1 both are asserted on the same tap.
REQ-030 A PIPE_LAT-deep shift register carries {o_acc_last, window index}, and o_out_we with o_out_addr appears exactly PIPE_LAT cycles after the matching o_acc_last.
REQ-031 This shift register always advances and is never frozen by i_stall.
REQ-032 When i_stall=1 in RUN, the counters hold and o_tap_valid, o_fm_rd, o_acc_clr and o_acc_last are all 0. Issue resumes with the held tap in the cycle after i_stall falls.
REQ-033 i_go is ignored while o_busy=1.
REQ-034 i_stall has no effect outside RUN.
REQ-035 All outputs are registered.
REQ-036 o_done rises one cycle after the final o_out_we.
REQ-037 With no stalls, the final o_out_we occurs at cycle OUT_SIZE^2*K^2 + PIPE_LAT, counting the i_go sample cycle as cycle 0.

Reset
REQ-038 While i_rst=1, the FSM returns to IDLE, all counters and the shift register clear, and every output is 0 on the next edge.
REQ-039 Reset mid-run aborts without emitting o_out_we or o_done.
REQ-040 i_rst takes priority over i_go arriving in the same cycle.

Verification
REQ-041 Default parameters (K=3, F=8, P=1, S=1, OUT=8, PIPE_LAT=3), single i_go at cycle 0, no stall:
- 576 o_tap_valid pulses in cycles 1..576;
- 64 o_out_we pulses, the last at cycle 579 with o_out_addr=63;
- o_done=1 only in cycle 580.
REQ-042 Default parameters, padding check:
- window 0 tap (0,0): o_pad_zero=1, o_fm_rd=0, o_acc_clr=1;
- window 0 tap (1,1): o_fm_addr=0, o_fm_rd=1;
- window 63 tap (2,2): o_pad_zero=1, o_acc_last=1.
REQ-043 K=3, F=7, P=0, S=2 (OUT=3), window (1,2) tap (0,0) -> o_fm_addr=18, o_w_addr=0, o_out_addr=5 written PIPE_LAT cycles after that window's o_acc_last.
REQ-044 Default parameters, i_stall held high for 5 cycles at tap 10 -> no tap issued during those 5 cycles, tap 10 reissued unchanged afterwards, o_done shifted by exactly 5 cycles to cycle 585.
REQ-045 Default parameters, i_go pulsed again at cycle 100 -> no effect; exactly one o_done, at cycle 580.
REQ-046 Default parameters, i_rst at cycle 200 -> all outputs 0 from cycle 201, no o_done. A fresh i_go then reproduces the REQ-041 timing relative to the new i_go.
